// File: rtl/uart_cmd_decoder_pkg.sv
// Shared definitions for the UART command decoder and the register slaves it writes:
// frame FSM encoding, default frame delimiters and the register address map.
package uart_cmd_decoder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA_H,
    ST_DATA_L,
    ST_CHK,
    ST_TAIL
  } state_t;

  localparam logic [7:0]  HEADER_DEFAULT  = 8'hAA;
  localparam logic [7:0]  TAIL_DEFAULT    = 8'h55;
  localparam logic [31:0] TIMEOUT_DEFAULT = 32'd2_500_000;

  // Register map shared by the decoder and every m_wr consumer
  localparam logic [7:0] DDS_En          = 8'd6;
  localparam logic [7:0] DDS_Fword_H     = 8'd7;
  localparam logic [7:0] DDS_Fword_L     = 8'd8;
  localparam logic [7:0] DDS_Pword       = 8'd9;
  localparam logic [7:0] DDS_S_Cnt_Max_L = 8'd10;
  localparam logic [7:0] DDS_S_Cnt_Max_H = 8'd11;
  localparam logic [7:0] DDS_Sample_En   = 8'd12;
  localparam logic [7:0] time_count      = 8'd13;

  // 8-bit wrap-around sum of the three payload bytes
  function automatic logic [7:0] frame_chk(input logic [7:0] addr,
                                           input logic [7:0] data_h,
                                           input logic [7:0] data_l);
    return addr + data_h + data_l;
  endfunction

endpackage

// File: rtl/frame_timeout.sv
// Inter-byte gap counter: cleared by clr, counts while en, flags the cycle it sits at TIMEOUT-1.
module frame_timeout #(
  parameter logic [31:0] TIMEOUT = 32'd2_500_000
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [31:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)      cnt <= '0;
    else if (clr)    cnt <= '0;
    else if (en)     cnt <= cnt + 32'd1;
  end

  assign tc = en && !clr && (cnt == TIMEOUT - 32'd1);

endmodule

// File: rtl/uart_cmd_decoder.sv
// Parses HEADER/ADDR/DATA_H/DATA_L/CHK/TAIL frames from the UART byte stream and
// issues one registered write per accepted frame; rejected frames pulse Frame_Err.
module uart_cmd_decoder
  import uart_cmd_decoder_pkg::*;
#(
  parameter logic [7:0]  HEADER  = HEADER_DEFAULT,
  parameter logic [7:0]  TAIL    = TAIL_DEFAULT,
  parameter logic [31:0] TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [7:0]  Rx_Byte,
  input  logic        Rx_Done,
  output logic        m_wr,
  output logic [7:0]  m_addr,
  output logic [15:0] m_wrdata,
  output logic        Frame_Err,
  output logic        Busy
);

  state_t     state, state_nxt;
  logic       wr_nxt, err_nxt;
  logic       tc;
  logic [7:0] addr_sh, data_h_sh, data_l_sh;

  frame_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .clr   (Rx_Done || (state == ST_IDLE)),
    .en    (state != ST_IDLE),
    .tc    (tc)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // A byte arriving on the terminal-count cycle takes priority over the timeout.
  always_comb begin
    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    state_nxt = state;
    wr_nxt    = 1'b0;
    err_nxt   = 1'b0;
    if (Rx_Done) begin
      case (state)
        ST_IDLE:   if (Rx_Byte == HEADER) state_nxt = ST_ADDR;
        ST_ADDR:   state_nxt = ST_DATA_H;
        ST_DATA_H: state_nxt = ST_DATA_L;
        ST_DATA_L: state_nxt = ST_CHK;
        ST_CHK: begin
          if (Rx_Byte == frame_chk(addr_sh, data_h_sh, data_l_sh)) begin
            state_nxt = ST_TAIL;
          end else begin
            state_nxt = ST_IDLE;
            err_nxt   = 1'b1;
          end
        end
        ST_TAIL: begin
          state_nxt = ST_IDLE;
          if (Rx_Byte == TAIL) wr_nxt  = 1'b1;
          else                 err_nxt = 1'b1;
        end
        default:   state_nxt = ST_IDLE;
      endcase
    end else if (tc) begin
      state_nxt = ST_IDLE;
      err_nxt   = 1'b1;
    end
  end

  // NOTE: shadow registers are reset too, so a frame cut short by reset cannot leak stale payload.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      addr_sh   <= '0;
      data_h_sh <= '0;
      data_l_sh <= '0;
    end else if (Rx_Done) begin
      case (state)
        ST_ADDR:   addr_sh   <= Rx_Byte;
        ST_DATA_H: data_h_sh <= Rx_Byte;
        ST_DATA_L: data_l_sh <= Rx_Byte;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      m_wr      <= 1'b0;
      m_addr    <= '0;
      m_wrdata  <= '0;
      Frame_Err <= 1'b0;
      Busy      <= 1'b0;
    end else begin
      m_wr      <= wr_nxt;
      Frame_Err <= err_nxt;
      Busy      <= (state_nxt != ST_IDLE);
      if (wr_nxt) begin
        m_addr   <= addr_sh;
        m_wrdata <= {data_h_sh, data_l_sh};
      end
    end
  end

endmodule

// File: doc/uart_cmd_decoder.md
# uart_cmd_decoder

Host-side register-write initiator for the DDS/scan register map. Parses fixed-length command frames from the UART receiver byte stream, validates header, checksum and tail, and issues single-cycle `m_wr`/`m_addr`/`m_wrdata` writes to the register slaves (DDS control, sample divider, excitation timer). Sits between the UART RX block and every `m_wr` consumer.

## Interface
- `HEADER`, default 8'hAA: frame start byte.
- `TAIL`, default 8'h55: frame end byte.
- `TIMEOUT`, default 32'd2_500_000: max Clk cycles between consecutive bytes of one frame (50 ms at 50 MHz).
- `Clk` in 1: system clock.
- `Rst_n` in 1: reset, asynchronous, active-low.
- `Rx_Byte` in 8: received byte, valid when `Rx_Done`=1.
- `Rx_Done` in 1: one-cycle strobe per received byte.
- `m_wr` out 1: one-cycle register write strobe.
- `m_addr` out 8: register address.
- `m_wrdata` out 16: register write data.
- `Frame_Err` out 1: one-cycle pulse on any rejected frame.
- `Busy` out 1: high while a frame is partially received (state != IDLE).

## Operation
- Frame: HEADER, ADDR, DATA_H, DATA_L, CHK, TAIL (6 bytes).
- CHK = (ADDR + DATA_H + DATA_L) mod 256, 8-bit wrap-around sum.
- States: IDLE, ADDR, DATA_H, DATA_L, CHK, TAIL. Every transition occurs only on a cycle with `Rx_Done`=1, except timeout.
- IDLE: byte == HEADER → ADDR; any other byte ignored silently (no `Frame_Err`).
- ADDR/DATA_H/DATA_L: latch byte into shadow registers, advance.
- CHK: byte != computed sum → `Frame_Err`, IDLE; else → TAIL.
- TAIL: byte == TAIL → write issued, IDLE; else `Frame_Err`, IDLE.
- No resynchronisation mid-frame: a HEADER value in ADDR..TAIL positions is treated as payload.
- Shadow registers do not drive outputs; `m_addr`/`m_wrdata` update only when a write is issued and hold until the next accepted frame.
- Timeout: gap counter cleared on every `Rx_Done` and while IDLE; counts otherwise. Reaching TIMEOUT-1 in any non-IDLE state → `Frame_Err`, IDLE. `Rx_Done` in the same cycle as the timeout terminal count wins: byte is processed, counter cleared, no error.
- Reset (any time, including mid-frame): state IDLE, `m_wr`=0, `m_addr`=8'h00, `m_wrdata`=16'h0000, `Frame_Err`=0, `Busy`=0, counter 0, shadows 0.

## Timing
- `m_wr` asserts exactly 1 cycle after the `Rx_Done` cycle carrying a valid TAIL; high for 1 cycle. `m_addr`/`m_wrdata` change on the same edge `m_wr` rises.
- `Frame_Err` asserts 1 cycle after the offending `Rx_Done` (or terminal count); 1 cycle wide.
- `m_wr` and `Frame_Err` are never high together.
- `Busy` is registered: rises 1 cycle after HEADER `Rx_Done`, falls in the cycle `m_wr`/`Frame_Err` is asserted.
- Back-to-back frames: a HEADER strobe in the cycle `m_wr` is asserted is accepted (state already IDLE).
- All outputs registered; no combinational path from inputs to outputs.

## Structure
- Shared package: state encoding typedef, default HEADER/TAIL constants, register address constants (`DDS_En`=6, `DDS_Fword_H`=7, `DDS_Fword_L`=8, `DDS_Pword`=9, `DDS_S_Cnt_Max_L`=10, `DDS_S_Cnt_Max_H`=11, `DDS_Sample_En`=12, `time_count`) so the decoder and slaves share one map.
- One sub-module: `frame_timeout` (clear/enable inputs, parameter TIMEOUT, terminal-count pulse output).

## Test plan
- Stream AA 07 00 83 8A 55 → one `m_wr` pulse, `m_addr`=8'h07, `m_wrdata`=16'h0083, `Frame_Err`=0.
- Stream AA 08 12 B0 CA 55 then immediately AA 0C 00 01 0D 55 → two `m_wr` pulses, (08, 12B0) then (0C, 0001); outputs hold 0C/0001 afterwards.
- Stream AA 07 00 83 8B 55 (bad CHK) → `Frame_Err` pulse after 5th byte, no `m_wr`, outputs unchanged; 6th byte 55 ignored in IDLE.
- Stream AA 07 00 83 8A 54 (bad TAIL) → `Frame_Err` after 6th byte, no `m_wr`.
- Stream AA 07 then silence ≥ TIMEOUT (TIMEOUT overridden to 100) → `Frame_Err` at cycle 100 after last strobe, `Busy`=0; following valid frame accepted. Also `Rx_Done` on exactly the terminal cycle → no error.
- Assert Rst_n low after AA 07 00 → all outputs reset values; subsequent 83 8A 55 ignored, no `m_wr`.
